spi_daisy_slave: RTL

SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) for daisy-chained operation. It runs entirely in the i_clk domain and oversamples i_sclk, i_mosi and i_ss. It shifts a word out on MISO while shifting a word in on MOSI. When no new transmit word is queued, each received word becomes the next transmitted word, so N instances in series form an N-word chain. It is the responder end for spi_master and sits one per device in a chain.

---
 rtl/spi_daisy_slave_if.sv | 26 ++
 rtl/spi_daisy_slave.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/spi_daisy_slave_if.sv
// SPI responder bus bundle: serial pins plus the parallel transmit/receive
// handshake. The slave modport is the responder's view; the master modport
// is the view of whoever drives the pins and the transmit queue.
interface spi_daisy_slave_if #(
  parameter int p_WORD_LEN = 8
);
  logic                  i_sclk;
  logic                  i_mosi;
  logic                  i_ss;
  logic [p_WORD_LEN-1:0] i_data;
  logic                  i_dv;
  logic                  o_miso;
  logic [p_WORD_LEN-1:0] o_data;
  logic                  o_dv;
  logic                  o_busy;

  modport slave (
    input  i_sclk, i_mosi, i_ss, i_data, i_dv,
    output o_miso, o_data, o_dv, o_busy
  );

  modport master (
    output i_sclk, i_mosi, i_ss, i_data, i_dv,
    input  o_miso, o_data, o_dv, o_busy
  );
endinterface

// File: rtl/spi_daisy_slave.sv
// Daisy-chainable SPI mode-0 responder, MSB first, fully in the i_clk domain.
// SCLK/MOSI/SS are oversampled; a received word is passed through as the next
// transmitted word unless a new word was queued via i_dv.
// Optional macro SPI_DAISY_SLAVE_OVERRUN_EN adds o_overrun, flagging a queued
// transmit word that was overwritten before being sent.
module spi_daisy_slave #(
  parameter int p_WORD_LEN    = 8,
  parameter int p_SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  spi_daisy_slave_if.slave   spi
`ifdef SPI_DAISY_SLAVE_OVERRUN_EN
  ,
  output logic               o_overrun
`endif
);

  localparam int CW = (p_WORD_LEN > 2) ? $clog2(p_WORD_LEN) : 1;

  typedef enum logic {IDLE, ACTIVE} state_e;

  logic [p_SYNC_STAGES-1:0] sclk_sync_q;
  logic [p_SYNC_STAGES-1:0] mosi_sync_q;
  logic [p_SYNC_STAGES-1:0] ss_sync_q;
  logic                     sclk_prev_q;
  logic                     ss_prev_q;

  logic sclk_s, mosi_s, ss_s;
  logic sclk_rise, sclk_fall, ss_fall, ss_rise;

  state_e                state_q;
  logic [p_WORD_LEN-1:0] shreg_q;
  logic [p_WORD_LEN-1:0] txbuf_q;
  logic                  pending_q;
  logic [CW-1:0]         bitcnt_q;
  logic                  cap_q;
  logic                  word_done_q;
  logic [p_WORD_LEN-1:0] data_q;
  logic                  dv_q;
  logic                  busy_q;
`ifdef SPI_DAISY_SLAVE_OVERRUN_EN
  logic                  overrun_q;
`endif

  // Synchronizers and edge-history flops. Deliberately not reset: a reset
  // taken while SS is held low must not manufacture an SS falling edge, so
  // resuming still needs a genuine deassert/reassert of SS.
  always_ff @(posedge i_clk) begin
    sclk_sync_q <= {sclk_sync_q[p_SYNC_STAGES-2:0], spi.i_sclk};
    mosi_sync_q <= {mosi_sync_q[p_SYNC_STAGES-2:0], spi.i_mosi};
    ss_sync_q   <= {ss_sync_q[p_SYNC_STAGES-2:0], spi.i_ss};
    sclk_prev_q <= sclk_sync_q[p_SYNC_STAGES-1];
    ss_prev_q   <= ss_sync_q[p_SYNC_STAGES-1];
  end

  assign sclk_s    = sclk_sync_q[p_SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[p_SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[p_SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q & ~ss_s;
  assign sclk_fall = ~sclk_s & sclk_prev_q & ~ss_s;
  assign ss_fall   = ~ss_s & ss_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;

  // Select FSM, transmit queue, shift register and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      txbuf_q     <= '0;
      pending_q   <= 1'b0;
      bitcnt_q    <= '0;
      cap_q       <= 1'b0;
      word_done_q <= 1'b0;
      data_q      <= '0;
      dv_q        <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SPI_DAISY_SLAVE_OVERRUN_EN
      overrun_q   <= 1'b0;
`endif
    end else begin
      dv_q <= 1'b0;
      if (spi.i_dv) txbuf_q <= spi.i_data;
`ifdef SPI_DAISY_SLAVE_OVERRUN_EN
      if (ss_rise)                       overrun_q <= 1'b0;
      else if (spi.i_dv && pending_q)    overrun_q <= 1'b1;
`endif
      case (state_q)
        IDLE: begin
          // A word queued while idle goes straight into the shifter so it is
          // on MISO before the first SCLK edge.
          if (spi.i_dv) begin
            shreg_q   <= spi.i_data;
            pending_q <= 1'b0;
          end else if (ss_fall && pending_q) begin
            shreg_q   <= txbuf_q;
            pending_q <= 1'b0;
          end
          if (ss_fall) begin
            state_q     <= ACTIVE;
            busy_q      <= 1'b1;
            bitcnt_q    <= '0;
            word_done_q <= 1'b0;
          end
        end
        ACTIVE: begin
          if (spi.i_dv) pending_q <= 1'b1;
          if (ss_rise) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            bitcnt_q    <= '0;
            word_done_q <= 1'b0;
          end else if (sclk_rise) begin
            cap_q <= mosi_s;
            if (bitcnt_q == CW'(p_WORD_LEN - 1)) begin
              data_q      <= {shreg_q[p_WORD_LEN-2:0], mosi_s};
              dv_q        <= 1'b1;
              bitcnt_q    <= '0;
              word_done_q <= 1'b1;
            end else begin
              bitcnt_q <= bitcnt_q + 1'b1;
            end
          end else if (sclk_fall) begin
            // At a word boundary a queued word (or one arriving this very
            // cycle, which wins) replaces the shifter; otherwise the final
            // shift leaves the received word in place for pass-through.
            word_done_q <= 1'b0;
            if (word_done_q && (pending_q || spi.i_dv)) begin
              shreg_q   <= spi.i_dv ? spi.i_data : txbuf_q;
              pending_q <= 1'b0;
            end else begin
              shreg_q <= {shreg_q[p_WORD_LEN-2:0], cap_q};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi.o_miso = shreg_q[p_WORD_LEN-1];
  assign spi.o_data = data_q;
  assign spi.o_dv   = dv_q;
  assign spi.o_busy = busy_q;
`ifdef SPI_DAISY_SLAVE_OVERRUN_EN
  assign o_overrun  = overrun_q;
`endif

endmodule
